// File: rtl/mdu_issue_ctrl_if.sv
// Request/response channel between the EXE-stage MDU initiator (master)
// and the multiply/divide unit (slave).
interface mdu_issue_ctrl_if #(
   parameter int DATA_W = 32
);
   logic                  mdu_req;
   logic [7:0]            mdu_operator;
   logic [2*DATA_W-1:0]   mdu_oprand;
   logic [2*DATA_W-1:0]   mdu_hilo_data;
   logic                  mdu_cancel;
   logic                  mdu_oprand_ok;
   logic                  mdu_data_ok;
   logic [1:0]            mdu_write_en;
   logic [2*DATA_W-1:0]   mdu_write_data;

   modport master (
      output mdu_req, mdu_operator, mdu_oprand, mdu_hilo_data, mdu_cancel,
      input  mdu_oprand_ok, mdu_data_ok, mdu_write_en, mdu_write_data
   );

   modport slave (
      input  mdu_req, mdu_operator, mdu_oprand, mdu_hilo_data, mdu_cancel,
      output mdu_oprand_ok, mdu_data_ok, mdu_write_en, mdu_write_data
   );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// EXE-stage initiator for the multiply/divide unit: issues requests, owns the
// architectural HI/LO registers, forwards MF reads and generates EXE stall.
module mdu_issue_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_valid_i,
   input  logic                op_mul_i,
   input  logic                op_div_i,
   input  logic                op_accum_i,
   input  logic                op_sub_i,
   input  logic                op_signed_i,
   input  logic                op_mthi_i,
   input  logic                op_mtlo_i,
   input  logic                op_mfhi_i,
   input  logic                op_mflo_i,
   input  logic [DATA_W-1:0]   src_a_i,
   input  logic [DATA_W-1:0]   src_b_i,
   input  logic                flush_i,
   mdu_issue_ctrl_if.master    mdu,
   output logic                stall_o,
   output logic [DATA_W-1:0]   mf_data_o,
   output logic                busy_o
);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic long_op, mt_op, mf_op, mdu_op, in_wait, issue_req, commit;
   logic [DATA_W-1:0] wb_hi, wb_lo;

   assign long_op   = op_mul_i | op_div_i | op_accum_i;
   assign mt_op     = op_mthi_i | op_mtlo_i;
   assign mf_op     = op_mfhi_i | op_mflo_i;
   assign mdu_op    = long_op | mt_op;
   assign in_wait   = (state_q == S_WAIT);
   assign issue_req = inst_valid_i & ~in_wait & ~flush_i & mdu_op;
   assign commit    = mdu.mdu_data_ok & ~flush_i;
   assign wb_hi     = mdu.mdu_write_data[2*DATA_W-1:DATA_W];
   assign wb_lo     = mdu.mdu_write_data[DATA_W-1:0];

   assign mdu.mdu_req       = issue_req;
   assign mdu.mdu_cancel    = flush_i & (in_wait | issue_req);
   assign mdu.mdu_hilo_data = {hi_q, lo_q};
   assign mdu.mdu_oprand    = inst_valid_i ? {src_b_i, src_a_i} : '0;
   assign mdu.mdu_operator  = inst_valid_i ?
      {op_mthi_i, mt_op, op_signed_i & op_div_i, op_div_i, op_sub_i,
       op_accum_i, op_signed_i & (op_mul_i | op_accum_i), op_mul_i | op_accum_i}
      : 8'h00;

   assign busy_o  = in_wait;
   assign stall_o = inst_valid_i & ~flush_i &
                    ((mdu_op & (in_wait | ~mdu.mdu_oprand_ok)) |
                     (mf_op & in_wait & ~mdu.mdu_data_ok));

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mf_data_o = '0;

      case (state_q)
         S_IDLE: if (inst_valid_i & long_op & mdu.mdu_oprand_ok & ~flush_i) state_d = S_WAIT;
         S_WAIT: if (mdu.mdu_data_ok | flush_i)                             state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (commit) begin
         if (mdu.mdu_write_en[1]) hi_d = wb_hi;
         if (mdu.mdu_write_en[0]) lo_d = wb_lo;
      end

      // A write-back landing this cycle is forwarded to the MF reader.
      if (inst_valid_i & op_mfhi_i)
         mf_data_o = (mdu.mdu_data_ok & mdu.mdu_write_en[1]) ? wb_hi : hi_q;
      else if (inst_valid_i & op_mflo_i)
         mf_data_o = (mdu.mdu_data_ok & mdu.mdu_write_en[0]) ? wb_lo : lo_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_mdu_issue_ctrl;

   typedef enum int {K_NONE, K_MUL, K_DIV, K_MADD, K_MSUB, K_MTHI, K_MTLO, K_MFHI, K_MFLO} kind_e;

   logic        clk, rst;
   logic        iv, op_mul, op_div, op_accum, op_sub, op_signed;
   logic        op_mthi, op_mtlo, op_mfhi, op_mflo, flush;
   logic [31:0] src_a, src_b;
   logic        stall, busy;
   logic [31:0] mf_data;

   mdu_issue_ctrl_if #(.DATA_W(32)) mdu ();

   mdu_issue_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .inst_valid_i(iv),
      .op_mul_i(op_mul), .op_div_i(op_div), .op_accum_i(op_accum), .op_sub_i(op_sub),
      .op_signed_i(op_signed), .op_mthi_i(op_mthi), .op_mtlo_i(op_mtlo),
      .op_mfhi_i(op_mfhi), .op_mflo_i(op_mflo), .src_a_i(src_a), .src_b_i(src_b),
      .flush_i(flush), .mdu(mdu), .stall_o(stall), .mf_data_o(mf_data), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Architectural model: HI/LO values and whether a long op is outstanding.
   logic [31:0] m_hi, m_lo;
   bit          m_wait;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_inst(input kind_e k, input logic sgn);
      {op_mul, op_div, op_accum, op_sub, op_mthi, op_mtlo, op_mfhi, op_mflo} = '0;
      op_signed = sgn;
      iv = (k != K_NONE);
      case (k)
         K_MUL:  op_mul = 1'b1;
         K_DIV:  op_div = 1'b1;
         K_MADD: op_accum = 1'b1;
         K_MSUB: begin op_accum = 1'b1; op_sub = 1'b1; end
         K_MTHI: op_mthi = 1'b1;
         K_MTLO: op_mtlo = 1'b1;
         K_MFHI: op_mfhi = 1'b1;
         K_MFLO: op_mflo = 1'b1;
         default: ;
      endcase
   endtask

   task automatic set_mdu(input logic ok, input logic dok, input logic [1:0] we,
                          input logic [63:0] wd, input logic fl);
      mdu.mdu_oprand_ok  = ok;
      mdu.mdu_data_ok    = dok;
      mdu.mdu_write_en   = we;
      mdu.mdu_write_data = wd;
      flush              = fl;
   endtask

   // Mid-cycle: compare every combinational output with the model's view.
   task automatic observe();
      logic        is_mdu, is_long, is_mf, e_req, e_stall;
      logic [7:0]  e_op;
      logic [31:0] e_mf;
      @(negedge clk);
      is_long = op_mul | op_div | op_accum;
      is_mdu  = is_long | op_mthi | op_mtlo;
      is_mf   = op_mfhi | op_mflo;
      e_req   = iv & !m_wait & !flush & is_mdu;
      e_stall = iv & !flush & ((is_mdu & (m_wait | !mdu.mdu_oprand_ok)) |
                               (is_mf & m_wait & !mdu.mdu_data_ok));
      e_op = 8'h00;
      if (iv) begin
         e_op[0] = op_mul | op_accum;
         e_op[1] = op_signed & (op_mul | op_accum);
         e_op[2] = op_accum;
         e_op[3] = op_sub;
         e_op[4] = op_div;
         e_op[5] = op_signed & op_div;
         e_op[6] = op_mthi | op_mtlo;
         e_op[7] = op_mthi;
      end
      e_mf = 32'h0;
      if (iv && op_mfhi)
         e_mf = (mdu.mdu_data_ok && mdu.mdu_write_en[1]) ? mdu.mdu_write_data[63:32] : m_hi;
      else if (iv && op_mflo)
         e_mf = (mdu.mdu_data_ok && mdu.mdu_write_en[0]) ? mdu.mdu_write_data[31:0] : m_lo;
      check("req",      64'(mdu.mdu_req),      64'(e_req));
      check("operator", 64'(mdu.mdu_operator), 64'(e_op));
      check("oprand",   mdu.mdu_oprand,        iv ? {src_b, src_a} : 64'h0);
      check("cancel",   64'(mdu.mdu_cancel),   64'(flush & (m_wait | e_req)));
      check("stall",    64'(stall),            64'(e_stall));
      check("mf_data",  64'(mf_data),          64'(e_mf));
      check("hilo",     mdu.mdu_hilo_data,     {m_hi, m_lo});
   endtask

   // Step the model across the clock edge, then compare the registered view.
   task automatic advance();
      if (rst) begin
         m_wait = 1'b0; m_hi = '0; m_lo = '0;
      end else begin
         if (mdu.mdu_data_ok && !flush) begin
            if (mdu.mdu_write_en[1]) m_hi = mdu.mdu_write_data[63:32];
            if (mdu.mdu_write_en[0]) m_lo = mdu.mdu_write_data[31:0];
         end
         if (!m_wait) m_wait = iv & (op_mul | op_div | op_accum) & mdu.mdu_oprand_ok & !flush;
         else         m_wait = !(mdu.mdu_data_ok | flush);
      end
      @(posedge clk);
      #1;
      check("busy",      64'(busy),         64'(m_wait));
      check("hilo_reg",  mdu.mdu_hilo_data, {m_hi, m_lo});
   endtask

   task automatic cycle();
      observe();
      advance();
   endtask

   logic [63:0] saved;

   initial begin
      rst = 1'b1; src_a = '0; src_b = '0;
      set_inst(K_NONE, 1'b0);
      set_mdu(1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
      m_wait = 1'b0; m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      advance();
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_hilo", mdu.mdu_hilo_data, 64'h0);
      rst = 1'b0;
      cycle();

      // Signed MULT, first waiting on oprand_ok then accepted.
      set_inst(K_MUL, 1'b1); src_a = 32'hFFFF_FFFE; src_b = 32'd3;
      observe();
      check("mult_op", 64'(mdu.mdu_operator), 64'h03);
      check("mult_stall_wait", 64'(stall), 64'h1);
      advance();
      set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      observe();
      check("mult_stall_ok", 64'(stall), 64'h0);
      advance();
      set_inst(K_NONE, 1'b0); set_mdu(1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
      cycle();
      set_mdu(1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
      cycle();
      check("mult_result", mdu.mdu_hilo_data, 64'hFFFF_FFFF_FFFF_FFFA);

      // DIV issue, then MFLO stalls until the quotient is forwarded.
      set_inst(K_DIV, 1'b0); src_a = 32'd15; src_b = 32'd2;
      set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      cycle();
      set_inst(K_MFLO, 1'b0); set_mdu(1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
      observe();
      check("mflo_stall", 64'(stall), 64'h1);
      advance();
      set_mdu(1'b0, 1'b1, 2'b11, {32'd1, 32'd7}, 1'b0);
      observe();
      check("mflo_fwd", 64'(mf_data), 64'd7);
      check("mflo_nostall", 64'(stall), 64'h0);
      advance();

      // MTHI completes in a single cycle and never leaves IDLE.
      set_inst(K_MTHI, 1'b0); src_a = 32'h1234_5678; src_b = 32'h0;
      set_mdu(1'b1, 1'b1, 2'b10, {32'h1234_5678, 32'hDEAD_BEEF}, 1'b0);
      observe();
      check("mthi_op", 64'(mdu.mdu_operator), 64'hC0);
      advance();
      check("mthi_hilo", mdu.mdu_hilo_data, {32'h1234_5678, 32'd7});
      check("mthi_idle", 64'(busy), 64'h0);

      // DIV followed by MULT: MULT waits for the DIV write-back.
      set_inst(K_DIV, 1'b1); src_a = 32'd100; src_b = 32'd9;
      set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      cycle();
      set_inst(K_MUL, 1'b0); src_a = 32'd5; src_b = 32'd6;
      set_mdu(1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
      observe();
      check("b2b_req_held", 64'(mdu.mdu_req), 64'h0);
      check("b2b_stall", 64'(stall), 64'h1);
      advance();
      set_mdu(1'b0, 1'b1, 2'b11, {32'd1, 32'd11}, 1'b0);
      observe();
      check("b2b_req_dok", 64'(mdu.mdu_req), 64'h0);
      advance();
      set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      observe();
      check("b2b_req_after", 64'(mdu.mdu_req), 64'h1);
      check("b2b_stall_after", 64'(stall), 64'h0);
      advance();

      // Flush during WAIT with a coincident data_ok: result is dropped.
      saved = mdu.mdu_hilo_data;
      set_inst(K_NONE, 1'b0);
      set_mdu(1'b0, 1'b1, 2'b11, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
      observe();
      check("flush_cancel", 64'(mdu.mdu_cancel), 64'h1);
      advance();
      check("flush_hilo", mdu.mdu_hilo_data, saved);
      check("flush_idle", 64'(busy), 64'h0);

      // Reset in the middle of a WAIT.
      set_inst(K_MADD, 1'b1); src_a = 32'd3; src_b = 32'd4;
      set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      cycle();
      check("pre_rst_busy", 64'(busy), 64'h1);
      set_inst(K_NONE, 1'b0); set_mdu(1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
      rst = 1'b1;
      advance();
      rst = 1'b0;
      check("rst_mid_hilo", mdu.mdu_hilo_data, 64'h0);
      check("rst_mid_busy", 64'(busy), 64'h0);
      set_inst(K_MUL, 1'b0); set_mdu(1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
      observe();
      check("rst_mid_stall", 64'(stall), 64'h0);
      advance();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         set_inst(kind_e'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) iv = 1'b0;
         src_a = $urandom; src_b = $urandom;
         set_mdu($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)), {$urandom, $urandom},
                 $urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 39) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
